// File: rtl/sticky_reg_bank.sv
// Sticky status register bank with irq mask, pending summary and registered irq.
// Reads/acks return one cycle after the strobe; no backpressure, every strobe is acknowledged.
module sticky_reg_bank #(
    parameter int NREGS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int W1C        = 1,
    localparam int AW        = $clog2(NREGS + 2)
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic [AW+2:3]               address,
    input  logic                        read_en,
    input  logic                        write_en,
    input  logic [31:0]                 write_data,
    output logic [31:0]                 read_data,
    output logic                        access_complete,
    output logic                        invalid_address,
    input  logic [NREGS*DATA_WIDTH-1:0] hw_set,
    input  logic [NREGS-1:0]            hw_set_en,
    output logic [NREGS*DATA_WIDTH-1:0] status,
    output logic                        irq
);

    logic [DATA_WIDTH-1:0]       irq_mask;
    logic [NREGS-1:0]            pend;
    logic [63:0]                 pend_ext;
    logic [31:0]                 rd_val;
    logic                        unmapped;
    logic [DATA_WIDTH-1:0]       wd;
    logic [DATA_WIDTH-1:0]       term;
    logic [DATA_WIDTH-1:0]       cur;
    logic [NREGS*DATA_WIDTH-1:0] status_nxt;
    int                          idx;

    always_comb begin
        idx = int'(address);
        wd  = write_data[DATA_WIDTH-1:0];
        for (int i = 0; i < NREGS; i++) begin
            pend[i] = |(status[i*DATA_WIDTH +: DATA_WIDTH] & irq_mask);
        end
        pend_ext = 64'(pend);

        rd_val   = '0;
        unmapped = 1'b0;
        if (idx < NREGS) begin
            rd_val[DATA_WIDTH-1:0] = status[idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (idx == NREGS) begin
            rd_val[DATA_WIDTH-1:0] = irq_mask;
        end else if (idx == NREGS + 1) begin
            rd_val = pend_ext[31:0];
        end else begin
            unmapped = 1'b1;
        end

        // A hardware set in the same cycle as a software write always survives.
        status_nxt = status;
        term       = '0;
        cur        = '0;
        for (int i = 0; i < NREGS; i++) begin
            term = hw_set_en[i] ? hw_set[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            cur  = status[i*DATA_WIDTH +: DATA_WIDTH];
            if (write_en && idx == i) begin
                if (W1C != 0) begin
                    status_nxt[i*DATA_WIDTH +: DATA_WIDTH] = (cur & ~wd) | term;
                end else begin
                    status_nxt[i*DATA_WIDTH +: DATA_WIDTH] = wd | term;
                end
            end else begin
                status_nxt[i*DATA_WIDTH +: DATA_WIDTH] = cur | term;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            status          <= '0;
            irq_mask        <= '0;
            read_data       <= '0;
            access_complete <= 1'b0;
            invalid_address <= 1'b0;
            irq             <= 1'b0;
        end else begin
            status          <= status_nxt;
            access_complete <= read_en | write_en;
            invalid_address <= (read_en | write_en) & unmapped;
            irq             <= |pend;
            if (read_en) begin
                read_data <= rd_val;
            end
            if (write_en && idx == NREGS) begin
                irq_mask <= wd;
            end
        end
    end

endmodule

// File: doc/sticky_reg_bank.md
STICKY_REG_BANK -- requirements
Module: sticky_reg_bank

Interface
REQ-001 SHALL have parameter NREGS, default 4, number of sticky status registers (1..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, status register width (1..32).
REQ-003 SHALL have parameter W1C, default 1: 1 = software write clears bits written as 1; 0 = software write overwrites.
REQ-004 SHALL have derived localparam AW = clog2(NREGS+2), the word-address width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-006 SHALL have port res, input, 1 bit, reset; asynchronous and active-high.
REQ-007 SHALL have port address, input, [AW+2:3], 8-byte-aligned register index.
REQ-008 SHALL have port read_en, input, 1 bit, software read strobe.
REQ-009 SHALL have port write_en, input, 1 bit, software write strobe.
REQ-010 SHALL have port write_data, input, 32 bits, software write data.
REQ-011 SHALL have port read_data, output reg, 32 bits, software read data.
REQ-012 SHALL have port access_complete, output reg, 1 bit, one-cycle acknowledge.
REQ-013 SHALL have port invalid_address, output reg, 1 bit, access to an unmapped index.
REQ-014 SHALL have port hw_set, input, NREGS*DATA_WIDTH bits, per-register set vector; register i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have port hw_set_en, input, NREGS bits, per-register enable for hw_set.
REQ-016 SHALL have port status, output reg, NREGS*DATA_WIDTH bits, current register contents.
REQ-017 SHALL have port irq, output reg, 1 bit, registered interrupt.

Function
REQ-018 SHALL use this map: index 0..NREGS-1 = status[i], read/write; index NREGS = irq_mask, DATA_WIDTH bits, read/write; index NREGS+1 = pending summary, read-only, bit i = |(status[i] & irq_mask). All other indices are unmapped.
REQ-019 SHALL OR the hw_set slice into status[i] on each cycle where hw_set_en[i]=1; a bit, once set, holds until cleared by software.
REQ-020 SHALL, on a software write to status[i] with W1C=1, compute next = (status & ~write_data) | hw_term, where hw_term = hw_set slice if hw_set_en[i]=1, else 0.
REQ-021 SHALL, on a software write to status[i] with W1C=0, compute next = write_data | hw_term; a set event arriving in the write cycle is never lost.
REQ-022 SHALL use write_data[DATA_WIDTH-1:0] only; read_data bits above DATA_WIDTH (and above NREGS for the summary) SHALL read 0.
REQ-023 SHALL register read_data, access_complete and invalid_address, valid one cycle after the strobe; read_data SHALL show the pre-write value when the strobe and a same-cycle update coincide.
REQ-024 SHALL pulse access_complete for exactly one cycle per cycle in which read_en or write_en is high, for mapped and unmapped indices alike.
REQ-025 SHALL raise invalid_address together with access_complete for an unmapped index; it SHALL be 0 otherwise.
REQ-026 SHALL ignore writes to the summary index and unmapped indices: no state changes, and invalid_address SHALL be 0 for the summary index.
REQ-027 SHALL, if read_en and write_en are high together, perform the write and return pre-write data.
REQ-028 SHALL register irq as the OR of all summary bits computed from current state, so irq follows a status or mask change by one cycle.

Reset
REQ-029 SHALL, while res=1 and independent of clk, drive all status bits, irq_mask, read_data, access_complete, invalid_address and irq to 0.
REQ-030 SHALL, when res asserts mid-access, drop any pending acknowledge; after release, the first rising edge SHALL operate normally.

Verification (NREGS=4, DATA_WIDTH=32, W1C=1)
REQ-031 SHALL cover: hw_set_en[1]=1 with slice 0x0000_00F0 for 1 cycle, then read index 1 -> read_data=0x0000_00F0 one cycle after read_en, access_complete pulsed 1 cycle.
REQ-032 SHALL cover: status[2]=0x0F, write 0x05 to index 2 while hw sets 0x01 in the same cycle -> status[2]=0x0B.
REQ-033 SHALL cover: status[0]=0x1, mask=0 -> irq=0; write mask=0x1 -> irq=1 two cycles after write_en; read index 5 -> 0x1.
REQ-034 SHALL cover: read index 7 -> invalid_address=1 and access_complete=1 for 1 cycle; write index 5 -> no state change, invalid_address=0.
REQ-035 SHALL cover: res pulsed asynchronously between clock edges with status nonzero -> status=0 and irq=0 immediately, before the next edge.
REQ-036 SHALL cover: rerun with W1C=0, write 0x3 to index 0 holding 0xC -> status[0]=0x3.
